// File: rtl/rv_pkg.sv
// Shared RV64 encodings used by the load/store path: access sizes and LSU FSM states.
package rv_pkg;

   typedef enum logic [2:0] {
      LS_B   = 3'b000,
      LS_H   = 3'b001,
      LS_W   = 3'b010,
      LS_D   = 3'b011,
      LS_BU  = 3'b100,
      LS_HU  = 3'b101,
      LS_WU  = 3'b110,
      LS_ILL = 3'b111
   } ls_size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: byte enables, store-data shift,
// access legality, and load-data extraction with sign/zero extension.
module lsu_align
   import rv_pkg::*;
(
   input  logic [2:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        wen,
   input  logic [63:0] wdata,
   input  logic [63:0] resp_rdata,
   output logic [7:0]  wmask,
   output logic [63:0] wdata_sh,
   output logic        err,
   output logic [63:0] rdata_ext
);

   logic [5:0]  sh;
   logic [63:0] rsh;
   logic [7:0]  size_mask;
   logic        misalign;

   assign sh       = {addr_lo, 3'b000};
   assign rsh      = resp_rdata >> sh;
   assign wdata_sh = wdata << sh;

   always_comb begin
      size_mask = 8'h01;
      misalign  = 1'b0;
      case (funct3[1:0])
         2'b00: begin size_mask = 8'h01; misalign = 1'b0;          end
         2'b01: begin size_mask = 8'h03; misalign = addr_lo[0];    end
         2'b10: begin size_mask = 8'h0F; misalign = |addr_lo[1:0]; end
         default: begin size_mask = 8'hFF; misalign = |addr_lo;    end
      endcase
   end

   assign wmask = size_mask << addr_lo;
   // Unsigned widths only exist for loads, so stores with funct3[2] set are illegal.
   assign err   = misalign | (funct3 == LS_ILL) | (wen & funct3[2]);

   always_comb begin
      rdata_ext = '0;
      case (funct3)
         LS_B:    rdata_ext = {{56{rsh[7]}},  rsh[7:0]};
         LS_H:    rdata_ext = {{48{rsh[15]}}, rsh[15:0]};
         LS_W:    rdata_ext = {{32{rsh[31]}}, rsh[31:0]};
         LS_D:    rdata_ext = rsh;
         LS_BU:   rdata_ext = {56'd0, rsh[7:0]};
         LS_HU:   rdata_ext = {48'd0, rsh[15:0]};
         LS_WU:   rdata_ext = {32'd0, rsh[31:0]};
         default: rdata_ext = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core memory op, issues one aligned masked bus
// request, waits for the response and returns extended data with a done pulse.
module lsu
   import rv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        lsu_wen,
   input  logic [2:0]  lsu_funct3,
   input  logic [63:0] lsu_addr,
   input  logic [63:0] lsu_wdata,
   output logic        lsu_done,
   output logic [63:0] lsu_rdata,
   output logic        lsu_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wen,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata
);

   lsu_state_e  state, state_nxt;
   logic [7:0]  cnt;
   logic        wen_q, err_q;
   logic [2:0]  f3_q;
   logic [63:0] addr_q, wdata_q, rdata_q;

   logic        idle, cnt_last, accept, finish_ok, finish_err;
   logic        op_wen;
   logic [2:0]  op_f3;
   logic [2:0]  op_addr_lo;
   logic [63:0] op_wdata;
   logic [7:0]  a_wmask;
   logic [63:0] a_wdata, a_rdata;
   logic        a_err;

   assign idle     = (state == ST_IDLE);
   assign cnt_last = (cnt == 8'(TIMEOUT - 1));

   // Legality is judged on the live inputs while idle, on the latched op afterwards.
   assign op_wen     = idle ? lsu_wen         : wen_q;
   assign op_f3      = idle ? lsu_funct3      : f3_q;
   assign op_addr_lo = idle ? lsu_addr[2:0]   : addr_q[2:0];
   assign op_wdata   = idle ? lsu_wdata       : wdata_q;

   lsu_align u_align (
      .addr_lo    (op_addr_lo),
      .funct3     (op_f3),
      .wen        (op_wen),
      .wdata      (op_wdata),
      .resp_rdata (mem_resp_rdata),
      .wmask      (a_wmask),
      .wdata_sh   (a_wdata),
      .err        (a_err),
      .rdata_ext  (a_rdata)
   );

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      case (state)
         ST_IDLE: if (lsu_valid) begin
            accept = 1'b1;
            if (a_err) begin
               state_nxt  = ST_DONE;
               finish_err = 1'b1;
            end else begin
               state_nxt = ST_REQ;
            end
         end
         // Timeout wins in REQ: a handshake on the last budget cycle would leave no room for the response.
         ST_REQ: if (cnt_last) begin
            state_nxt  = ST_DONE;
            finish_err = 1'b1;
         end else if (mem_req_ready) begin
            state_nxt = ST_WAIT;
         end
         ST_WAIT: if (mem_resp_valid) begin
            state_nxt = ST_DONE;
            finish_ok = 1'b1;
         end else if (cnt_last) begin
            state_nxt  = ST_DONE;
            finish_err = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         wen_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            wen_q   <= lsu_wen;
            f3_q    <= lsu_funct3;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
         end
         if (idle)
            cnt <= '0;
         else if (state == ST_REQ || state == ST_WAIT)
            cnt <= cnt + 8'd1;
         if (finish_ok) begin
            rdata_q <= wen_q ? '0 : a_rdata;
            err_q   <= 1'b0;
         end else if (finish_err) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   assign lsu_ready     = ~rst & idle;
   assign lsu_done      = ~rst & (state == ST_DONE);
   assign lsu_rdata     = lsu_done ? rdata_q : '0;
   assign lsu_err       = lsu_done & err_q;
   assign mem_req_valid = ~rst & (state == ST_REQ);
   assign mem_req_wen   = mem_req_valid & wen_q;
   assign mem_req_addr  = mem_req_valid ? {addr_q[63:3], 3'b000} : '0;
   assign mem_req_wdata = (mem_req_valid & wen_q) ? a_wdata : '0;
   assign mem_req_wmask = (mem_req_valid & wen_q) ? a_wmask : '0;

endmodule
